// File: rtl/data_mem_responder_pkg.sv
// Shared constants, FSM state type and address helper for the data memory responder.
// Imported by data_mem_responder and dmem_array.
package data_mem_responder_pkg;

   localparam int XLEN  = 32;
   localparam int BE_W  = XLEN / 8;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } dmr_state_e;

   function automatic int word_addr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port byte-enabled word storage with synchronous write and registered read.
// Ports: clk, reset, en (access strobe), we, blank (force read data to 0), idx, be, wdata, rdata.
module dmem_array
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic            we,
   input  logic            blank,
   input  logic [AW-1:0]   idx,
   input  logic [BE_W-1:0] be,
   input  logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] rdata
);

   logic [XLEN-1:0] mem_q [DEPTH];
   logic [XLEN-1:0] rdata_q;
   logic [XLEN-1:0] rdata_d;

   // Contents are never cleared; only enabled bytes of a clean store change.
   always_ff @(posedge clk) begin
      if (en && we && !blank) begin
         for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
               mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   // Read register doubles as the response data: stores and faults return 0.
   always_comb begin
      rdata_d = rdata_q;
      if (en) begin
         rdata_d = (we || blank) ? '0 : mem_q[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: serialises CPU load/store requests with a fixed wait latency.
// Ports: clk, reset, req_* (valid/ready request channel), rsp_* (valid/ready response channel).
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [BE_W-1:0] req_be,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_err
);

   localparam int AW = word_addr_w(DEPTH);

   dmr_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            wr_q, wr_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [BE_W-1:0] be_q, be_d;
   logic            err_q, err_d;

   logic            access;
   logic            fault;

   // Upper address bits above the array range must be zero.
   assign fault  = (addr_q[1:0] != 2'b00) ||
                   (addr_q[XLEN-1:AW+2] != '0);
   assign access = (state_q == WAIT) && (cnt_q == '0);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      err_d     = err_q;
      req_ready = (state_q == IDLE);
      rsp_valid = (state_q == RESP);
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               wr_d    = req_write;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               be_d    = req_be;
               cnt_d   = CNT_W'(WAIT_CYCLES);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               err_d   = fault;
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         err_q   <= err_d;
      end
   end

   // Reset wins over an access edge, so an abandoned store never lands.
   dmem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .reset (reset),
      .en    (access && !reset),
      .we    (wr_q),
      .blank (fault),
      .idx   (addr_q[AW+1:2]),
      .be    (be_q),
      .wdata (wdata_q),
      .rdata (rsp_rdata)
   );

   assign rsp_err = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed table, reset abort,
// zero-wait throughput and randomized traffic against a word-array model.
module tb_data_mem_responder;

   localparam int DEPTH = 256;
   localparam int W     = 2;

   logic        clk = 0;
   logic        reset = 1;
   logic        req_valid = 0, req_write = 0;
   logic [31:0] req_addr = 0, req_wdata = 0;
   logic [3:0]  req_be = 0;
   logic        rsp_ready = 0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   logic        req_valid1 = 1, rsp_ready1 = 1;
   logic        req_ready1, rsp_valid1, rsp_err1;
   logic [31:0] rsp_rdata1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   data_mem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) dut0w (
      .clk(clk), .reset(reset),
      .req_valid(req_valid1), .req_ready(req_ready1),
      .req_write(1'b0), .req_addr(32'h0),
      .req_wdata(32'h0), .req_be(4'h0),
      .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
      .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // One full transaction; response held for 'hold' cycles before rsp_ready.
   task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input int hold,
                      output logic [31:0] rd, output logic er, output int lat);
      int n;
      @(negedge clk);
      req_write = w; req_addr = a; req_wdata = d; req_be = be;
      req_valid = 1; rsp_ready = 0;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("accept_timeout", 32'(n), 32'(0));
      @(posedge clk);
      #1;
      req_valid = 0;
      req_write = ~w; req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
      lat = 0;
      while (!rsp_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (lat >= 50) chk("rsp_timeout", 32'(lat), 32'(W + 1));
      rd = rsp_rdata;
      er = rsp_err;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", 32'(rsp_valid), 32'(1));
         chk("hold_rdata", rsp_rdata, rd);
         chk("hold_err", 32'(rsp_err), 32'(er));
         chk("hold_req_ready", 32'(req_ready), 32'(0));
      end
      rsp_ready = 1;
      @(posedge clk);
      #1;
      rsp_ready = 0;
      chk("post_req_ready", 32'(req_ready), 32'(1));
      chk("post_rsp_valid", 32'(rsp_valid), 32'(0));
   endtask

   typedef struct {
      bit          w;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
      int          hold;
      logic [31:0] er_d;
      bit          ee;
   } vec_t;

   vec_t        tbl[16];
   logic [31:0] mem_m [DEPTH];

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;

      tbl[0]  = '{1, 32'h10,  32'hDEADBEEF, 4'hF, 0, 32'h0,        0};
      tbl[1]  = '{0, 32'h10,  32'h0,        4'h0, 5, 32'hDEADBEEF, 0};
      tbl[2]  = '{1, 32'h10,  32'h11223344, 4'h5, 0, 32'h0,        0};
      tbl[3]  = '{0, 32'h10,  32'h0,        4'h0, 0, 32'hDE22BE44, 0};
      tbl[4]  = '{0, 32'h12,  32'h0,        4'h0, 0, 32'h0,        1};
      tbl[5]  = '{0, 32'h400, 32'h0,        4'h0, 0, 32'h0,        1};
      tbl[6]  = '{1, 32'h0,   32'hAAAA5555, 4'hF, 0, 32'h0,        0};
      tbl[7]  = '{1, 32'h400, 32'h12345678, 4'hF, 0, 32'h0,        1};
      tbl[8]  = '{0, 32'h0,   32'h0,        4'h0, 1, 32'hAAAA5555, 0};
      tbl[9]  = '{1, 32'h4,   32'h01020304, 4'hF, 0, 32'h0,        0};
      tbl[10] = '{1, 32'h4,   32'hFFFFFFFF, 4'h0, 0, 32'h0,        0};
      tbl[11] = '{0, 32'h4,   32'h0,        4'h0, 0, 32'h01020304, 0};
      tbl[12] = '{1, 32'h3FC, 32'h89ABCDEF, 4'hF, 0, 32'h0,        0};
      tbl[13] = '{0, 32'h3FC, 32'h0,        4'h0, 2, 32'h89ABCDEF, 0};
      tbl[14] = '{1, 32'h20,  32'h13579BDF, 4'hF, 0, 32'h0,        0};
      tbl[15] = '{0, 32'hFFFFFFFC, 32'h0,   4'h0, 0, 32'h0,        1};

      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 0;
      chk("rst_req_ready", 32'(req_ready), 32'(1));
      chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_err", 32'(rsp_err), 32'(0));

      // Zero-wait instance: accept, access, handshake repeats every 3 cycles.
      for (int i = 0; i < 9; i++) begin
         chk("w0_req_ready", 32'(req_ready1), 32'((i % 3) == 0));
         chk("w0_rsp_valid", 32'(rsp_valid1), 32'((i % 3) == 2));
         @(negedge clk);
      end
      req_valid1 = 0;

      for (int i = 0; i < 16; i++) begin
         txn(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be, tbl[i].hold, rd, er, lat);
         chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(W + 1));
         chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].er_d);
         chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].ee));
      end

      // Reset one cycle after accepting a store: transaction must vanish.
      @(negedge clk);
      req_write = 1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
      req_valid = 1;
      chk("abort_ready", 32'(req_ready), 32'(1));
      @(posedge clk);
      #1;
      req_valid = 0;
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      chk("abort_req_ready", 32'(req_ready), 32'(1));
      for (int i = 0; i < 6; i++) begin
         chk("abort_rsp_valid", 32'(rsp_valid), 32'(0));
         @(negedge clk);
      end
      txn(0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
      chk("abort_load", rd, 32'h13579BDF);
      chk("abort_err", 32'(er), 32'(0));

      // Randomized traffic against a word-array model over words 0..15.
      for (int i = 0; i < 16; i++) begin
         mem_m[i] = $urandom;
         txn(1, 32'(i * 4), mem_m[i], 4'hF, 0, rd, er, lat);
      end
      for (int k = 0; k < 40; k++) begin
         bit          w, ee;
         logic [31:0] a, d, ed;
         logic [3:0]  be;
         int          r, hold;
         r    = $urandom_range(0, 7);
         w    = 1'($urandom);
         d    = $urandom;
         be   = 4'($urandom);
         hold = $urandom_range(0, 2);
         if (r < 6)       a = 32'($urandom_range(0, 15) * 4);
         else if (r == 6) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
         else             a = 32'h400 + ($urandom & 32'h00FF_FFFC);
         ee = (a % 4 != 0) || (a >= 4 * DEPTH);
         ed = 32'h0;
         if (!ee && w) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) mem_m[a / 4][8*b +: 8] = d[8*b +: 8];
         end else if (!ee) begin
            ed = mem_m[a / 4];
         end
         txn(w, a, d, be, hold, rd, er, lat);
         chk($sformatf("rnd%0d_lat", k), 32'(lat), 32'(W + 1));
         chk($sformatf("rnd%0d_rdata", k), rd, ed);
         chk($sformatf("rnd%0d_err", k), 32'(er), 32'(ee));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
